// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch unit and the core top:
//   - ifu_state_e      : fetch FSM states (request / wait for data / hold output)
//   - RESP_OKAY        : AXI read response value meaning "no fault"
//   - RESET_PC_DEFAULT : architectural reset PC shared with the core top
//   - ifu_align_pc()   : forces a redirect target onto a word boundary
//   - ifu_pc_incr()    : sequential next-PC (+4, wraps modulo 2^32)
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Instructions are word aligned; the low two target bits carry no meaning.
    function automatic logic [31:0] ifu_align_pc(input logic [31:0] target);
        return target & PC_ALIGN_MASK;
    endfunction

    // Sequential successor; the carry out of bit 31 is intentionally dropped.
    function automatic logic [31:0] ifu_pc_incr(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_next.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pc_next
// Combinational next-PC select for the fetch unit. A redirect always wins over
// sequential advance; with neither, the PC holds.
// Ports:
//   i_pc       in  32 : current PC
//   i_jump     in   1 : redirect strobe
//   i_jump_pc  in  32 : redirect target (low two bits discarded)
//   i_advance  in   1 : current instruction accepted by decode, step by 4
//   o_pc_next  out 32 : PC value for the next cycle
// -----------------------------------------------------------------------------
module inst_fetch_unit_pc_next
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc,
    input  logic        i_advance,
    output logic [31:0] o_pc_next
);

    // Priority mux: redirect, then sequential step, else hold.
    always_comb begin
        o_pc_next = i_pc;
        if (i_jump) begin
            o_pc_next = ifu_align_pc(i_jump_pc);
        end else if (i_advance) begin
            o_pc_next = ifu_pc_incr(i_pc);
        end else begin
            o_pc_next = i_pc;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Producer end of the fetch->decode valid/ready link. Owns the PC, issues a
// single outstanding read on an AXI4-Lite style read channel and presents
// {inst, pc, err} to decode. A redirect discards in-flight or held work and
// restarts fetching from the (word aligned) target.
// Ports:
//   clock, reset            : single clock, synchronous active-high reset
//   jump, jump_pc           : redirect strobe and target from execute
//   araddr/arvalid/arready  : read address channel (araddr is always the PC)
//   rdata/rresp/rvalid/rready : read data channel (rresp != 0 is a fault)
//   inst_out/pc_out/inst_err  : registered instruction, its address, fault flag
//   out_valid/out_ready     : handshake toward decode
// All outputs are registers or decodes of the state register only, so no
// input has a combinational path to any output.
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_err,
    output logic        out_valid,
    input  logic        out_ready
);

    ifu_state_e  r_state;
    logic [31:0] r_pc;
    logic        r_flush_pend;   // a read issued for a stale PC is still owed
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_err;

    logic        w_advance;
    logic [31:0] w_pc_next;

    // Decode accepted the held instruction and no redirect overrides it.
    assign w_advance = (r_state == IFU_HOLD) && out_ready && !jump;

    inst_fetch_unit_pc_next u_pc_next (
        .i_pc      (r_pc),
        .i_jump    (jump),
        .i_jump_pc (jump_pc),
        .i_advance (w_advance),
        .o_pc_next (w_pc_next)
    );

    // Fetch FSM, PC register and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IFU_REQ;
            r_pc         <= RESET_PC;
            r_flush_pend <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_pc_out     <= RESET_PC;
            r_err        <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                IFU_REQ: begin
                    // A jump without arready just retargets araddr (no handshake
                    // yet). A jump with arready means the read just issued is
                    // for the old PC and its data must be thrown away.
                    if (arready) begin
                        r_state <= IFU_WAIT;
                        if (jump) begin
                            r_flush_pend <= 1'b1;
                        end else begin
                            r_flush_pend <= r_flush_pend;
                        end
                    end else begin
                        r_state <= IFU_REQ;
                    end
                end
                IFU_WAIT: begin
                    if (rvalid) begin
                        if (r_flush_pend || jump) begin
                            // Stale response: drop it; r_pc already holds the target.
                            r_flush_pend <= 1'b0;
                            r_state      <= IFU_REQ;
                        end else begin
                            r_inst   <= rdata;
                            r_pc_out <= r_pc;
                            r_err    <= (rresp != RESP_OKAY);
                            r_state  <= IFU_HOLD;
                        end
                    end else begin
                        if (jump) begin
                            r_flush_pend <= 1'b1;
                        end else begin
                            r_flush_pend <= r_flush_pend;
                        end
                        r_state <= IFU_WAIT;
                    end
                end
                IFU_HOLD: begin
                    // A redirect discards the held instruction even when decode
                    // is accepting in the same cycle; w_advance excludes that case.
                    if (jump || out_ready) begin
                        r_state <= IFU_REQ;
                    end else begin
                        r_state <= IFU_HOLD;
                    end
                end
                default: begin
                    r_state      <= IFU_REQ;
                    r_flush_pend <= 1'b0;
                end
            endcase
        end
    end

    assign araddr    = r_pc;
    assign arvalid   = (r_state == IFU_REQ);
    assign rready    = (r_state == IFU_WAIT);
    assign out_valid = (r_state == IFU_HOLD);
    assign inst_out  = r_inst;
    assign pc_out    = r_pc_out;
    assign inst_err  = r_err;

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit: the producer end of the fetch→decode valid/ready link consumed by `ysyx_20020207_IDU`. It owns the PC, issues one instruction read at a time on an AXI4-Lite-style read channel, and presents `{inst, pc}` to decode. On a redirect (`jump`) it discards in-flight or held work and restarts from the target.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC of the first fetch after reset.

Ports:
- `clock`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `jump`  in  1: redirect strobe from execute; same signal that flushes decode.
- `jump_pc`  in  32: redirect target; bits [1:0] ignored and forced to 0.
- `araddr`  out  32: read address, always the current PC.
- `arvalid`  out  1: read-address valid.
- `arready`  in  1: read-address ready.
- `rdata`  in  32: read data.
- `rresp`  in  2: read response; non-zero means access fault.
- `rvalid`  in  1: read-data valid.
- `rready`  out  1: read-data ready.
- `inst_out`  out  32: fetched instruction.
- `pc_out`  out  32: address of `inst_out`.
- `inst_err`  out  1: `inst_out` came back with `rresp != 0`.
- `out_valid`  out  1: `{inst_out, pc_out, inst_err}` is valid toward decode.
- `out_ready`  in  1: decode accepts (decode's `in_ready`).

## Operation
- Internal state: `pc` (32-bit), `flush_pend` (1-bit), and a 3-state FSM:
  - **REQ**: `arvalid=1`. On `arready`, go to **WAIT**.
  - **WAIT**: `rready=1`. On `rvalid`:
    - If `flush_pend` or `jump` is set: drop the data, clear `flush_pend`, go to **REQ**. `pc` already holds the target.
    - Otherwise: latch `rdata`, `pc` and `rresp!=0` into the output registers and go to **HOLD**.
  - **HOLD**: `out_valid=1`. On `out_ready`: `pc <= pc + 4` (mod 2^32 wrap) and go to **REQ**.
- Redirect handling (`jump` high in any state, outside reset):
  - `pc <= {jump_pc[31:2], 2'b00}`.
  - HOLD: `out_valid` drops next cycle and the held instruction is discarded, even if `out_ready` is also high; go to REQ.
  - WAIT with `rvalid` in the same cycle: that response is discarded and the FSM goes to REQ.
  - WAIT without `rvalid`: set `flush_pend`; the late response is discarded when it arrives.
  - REQ before `arready`: `arvalid` stays high and `araddr` switches to the target next cycle. The address change is allowed here because no handshake has occurred yet.
  - REQ with `arready` in the same cycle: the issued read is stale. Set `flush_pend` and go to WAIT.
- Handshake rules:
  - Exactly one read outstanding; `arvalid` and `rready` are never high together.
  - `arvalid` never drops before `arready`, except on reset.
  - `out_valid` and the output data are stable until `out_ready` or `jump`.
- Error handling: a fault is delivered like a normal instruction, with `inst_err=1`. The fetch unit takes no further action; decode/execute raise the exception.
- Reset (synchronous, wins over every other input, valid mid-transaction):
  - FSM ← REQ, `pc` ← `RESET_PC`, `flush_pend` ← 0.
  - `out_valid` ← 0, `inst_out` ← 0, `pc_out` ← `RESET_PC`, `inst_err` ← 0.
  - A memory response that was in flight before reset must not appear on the outputs.

## Timing
- Reset values:
  - `arvalid=1` and `araddr=RESET_PC` during and after reset.
  - `rready=0`, `out_valid=0`.
- Cycle numbering, with zero wait states:
  - C0: AR handshake.
  - C1: `rvalid` at the earliest; R handshake.
  - C2: `out_valid=1`. If `out_ready` is high in C2, the next `arvalid` is in C3.
- Latency: minimum 3 cycles per instruction, non-overlapped, which matches decode's one-at-a-time `in_ready`.
- Redirect: `jump` in cycle N puts the target on `araddr` in cycle N+1 (REQ) or after the pending response is drained (WAIT).
- All outputs are registered or driven purely from FSM state; there is no combinational path from `out_ready` or `rvalid` to any output.

## Structure
- Shared package (`ysyx_20020207_pkg`): FSM state enum (`IFU_REQ`, `IFU_WAIT`, `IFU_HOLD`), the `RESP_OKAY` constant, and a `RESET_PC` default shared with the core top.
- No sub-module: a single FSM plus the PC register and output registers.
- Optionally factor out `ifu_pc_next`: a combinational mux over reset/jump/+4.

## Test plan
- Reset, then a zero-wait memory returning `32'h00000413` with `out_ready=1`:
  - first fetch at `8000_0000`, `out_valid` in cycle 3;
  - second `araddr` is `8000_0004`.
- Decode stalls (`out_ready=0` for 5 cycles):
  - `out_valid`, `inst_out` and `pc_out` stay constant;
  - no new `arvalid`;
  - release → next fetch at `pc+4`.
- `jump` with `jump_pc=8000_0103` during WAIT, with `rvalid` 4 cycles later:
  - stale data is never presented;
  - next `araddr` is `8000_0100`.
- `jump` in HOLD coinciding with `out_ready=1`:
  - `out_valid` goes low next cycle;
  - `araddr=jump target`;
  - the PC does not advance by 4.
- `rresp=2'b10` on a fetch at `8000_0008`:
  - `inst_err=1` with `pc_out=8000_0008`;
  - next fetch at `8000_000C`.
- Reset asserted in WAIT, then a late `rvalid`:
  - the response is ignored;
  - the fetch restarts at `RESET_PC`;
  - `out_valid` stays 0.
